mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: CLK input 1 (all state updates on rising edge); RESET input 1 (synchronous, active-high).
REQ-002 d_read  input  1  data-cache block read request.
REQ-003 d_write  input  1  data-cache block write request (d_read and d_write are never both high).
REQ-004 d_address  input  6  data-cache block address.
REQ-005 d_writedata  input  32  data-cache write block.
REQ-006 d_readdata  output  32  registered read block returned to the data cache.
REQ-007 d_busywait  output  1  data-cache stall; high while its request is pending and not yet complete.
REQ-008 i_read  input  1  instruction-cache block read request (read-only requester).
REQ-009 i_address  input  6  instruction-cache block address.
REQ-010 i_readdata  output  32  registered read block returned to the instruction cache.
REQ-011 i_busywait  output  1  instruction-cache stall.
REQ-012 mem_read, mem_write  output  1 each  forwarded to data_memory.
REQ-013 mem_address  output  6; mem_writedata  output  32  forwarded to data_memory.
REQ-014 mem_readdata  input  32; mem_busywait  input  1  returned from data_memory.

Function
REQ-015 FSM states SHALL be IDLE, D_ACC, I_ACC and RELEASE.
REQ-016 IDLE: no pending request -> stay in IDLE. Only D pending -> D_ACC. Only I pending -> I_ACC. Both pending -> grant the requester not served last (last_grant register), with transition on the next edge.
REQ-017 In D_ACC, mem_read, mem_write, mem_address and mem_writedata SHALL combinationally equal d_read, d_write, d_address and d_writedata. In I_ACC, mem_read=i_read, mem_write=0, mem_address=i_address and mem_writedata=0. In IDLE and RELEASE, all mem_* outputs SHALL be 0.
REQ-018 A 1-bit started flag SHALL be set on the first edge in D_ACC or I_ACC and cleared on leaving the state. Completion = grant state AND started AND mem_busywait==0.
REQ-019 On the completion cycle, the granted requester's busywait SHALL be 0 combinationally. At that edge, mem_readdata SHALL be latched into that requester's readdata register (reads only), last_grant SHALL be updated, and the FSM SHALL go to RELEASE.
REQ-020 RELEASE SHALL last exactly 1 cycle with mem_read=mem_write=0, then go to IDLE; there is no back-to-back grant without RELEASE.
REQ-021 d_busywait = (d_read|d_write) AND NOT d-completion AND NOT RESET. i_busywait = i_read AND NOT i-completion AND NOT RESET. A waiting (ungranted) requester SHALL see busywait=1.
REQ-022 Withdrawal: if the granted requester's request drops before completion, the FSM SHALL go to RELEASE, its readdata SHALL NOT update, and last_grant SHALL still update.
REQ-023 Minimum grant latency SHALL be 1 cycle (IDLE -> grant). Arbitration overhead per access SHALL be 2 cycles (grant entry + RELEASE) plus the memory latency.
REQ-024 readdata registers SHALL hold their value until the next completed read for the same requester.
REQ-025 The ungranted requester's readdata SHALL be unaffected by the other requester's accesses.

Reset
REQ-026 While RESET=1 at an edge: state=IDLE, started=0, last_grant=I (data cache wins the first tie), d_readdata=i_readdata=0.
REQ-027 While RESET=1: d_busywait=i_busywait=0.
REQ-028 Reset mid-access SHALL abandon the transfer: mem_read/mem_write SHALL be 0 from the cycle after the reset edge, and no readdata update occurs.

Verification
REQ-029 Single D read: mem[5]=0x05050505, d_read=1, d_address=5 -> mem_read=1, mem_address=5 from the next cycle; d_busywait falls on the cycle mem_busywait falls; d_readdata=0x05050505; 1 RELEASE cycle seen.
REQ-030 Single D write: d_write=1, d_address=0x21, d_writedata=0xDEADBEEF -> mem_write=1 with matching address/data; a subsequent D read of 0x21 returns 0xDEADBEEF; i_readdata unchanged.
REQ-031 Tie after reset: d_read and i_read raised on the same edge -> D served first with i_busywait=1 throughout; I granted exactly 1 cycle after D's RELEASE.
REQ-032 Fairness: both requesters continuously requesting for 4 accesses -> grant order D, I, D, I; no requester waits more than one access.
REQ-033 Withdrawal: i_read dropped 3 cycles into I_ACC -> RELEASE, then IDLE; i_readdata keeps its previous value.
REQ-034 Reset mid-access: RESET=1 during D_ACC -> mem_read=0 next cycle, busywaits=0, both readdata=0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a data cache (read/write) and an instruction
// cache (read-only) share one data_memory port.
// Ports:
//   clk, reset                  - single clock, synchronous active-high reset
//   d_read/d_write/d_address/d_writedata, d_readdata, d_busywait - data cache
//   i_read/i_address, i_readdata, i_busywait                     - instr cache
//   mem_read/mem_write/mem_address/mem_writedata                 - to memory
//   mem_readdata, mem_busywait                                   - from memory
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [5:0]  d_address,
  input  logic [31:0] d_writedata,
  output logic [31:0] d_readdata,
  output logic        d_busywait,
  input  logic        i_read,
  input  logic [5:0]  i_address,
  output logic [31:0] i_readdata,
  output logic        i_busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_ACC   = 2'd1,
    I_ACC   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // last_grant encoding: which requester was served most recently
  localparam logic GRANT_D = 1'b0;
  localparam logic GRANT_I = 1'b1;

  state_t state_q, state_d;
  logic   started_q, started_d;
  logic   last_grant_q, last_grant_d;
  logic   d_load, i_load;
  logic   d_done, i_done;
  logic   d_req, i_req;

  assign d_req = d_read | d_write;
  assign i_req = i_read;

  // Next-state, memory port steering and completion detection
  always_comb begin
    state_d       = state_q;
    started_d     = started_q;
    last_grant_d  = last_grant_q;
    d_load        = 1'b0;
    i_load        = 1'b0;
    d_done        = 1'b0;
    i_done        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = ADDR_W'(0);
    mem_writedata = DATA_W'(0);

    case (state_q)
      IDLE: begin
        started_d = 1'b0;
        if (d_req && i_req) begin
          // tie: serve whoever was not served last
          state_d = (last_grant_q == GRANT_I) ? D_ACC : I_ACC;
        end else if (d_req) begin
          state_d = D_ACC;
        end else if (i_req) begin
          state_d = I_ACC;
        end
      end

      D_ACC: begin
        mem_read      = d_read;
        mem_write     = d_write;
        mem_address   = d_address;
        mem_writedata = d_writedata;
        if (!d_req) begin
          // withdrawn before completion: drop the access, no data update
          state_d      = RELEASE;
          started_d    = 1'b0;
          last_grant_d = GRANT_D;
        end else if (started_q && !mem_busywait) begin
          d_done       = 1'b1;
          d_load       = d_read;
          state_d      = RELEASE;
          started_d    = 1'b0;
          last_grant_d = GRANT_D;
        end else begin
          // first cycle: memory has not seen the request yet
          started_d = 1'b1;
        end
      end

      I_ACC: begin
        mem_read    = i_read;
        mem_address = i_address;
        if (!i_req) begin
          state_d      = RELEASE;
          started_d    = 1'b0;
          last_grant_d = GRANT_I;
        end else if (started_q && !mem_busywait) begin
          i_done       = 1'b1;
          i_load       = 1'b1;
          state_d      = RELEASE;
          started_d    = 1'b0;
          last_grant_d = GRANT_I;
        end else begin
          started_d = 1'b1;
        end
      end

      RELEASE: begin
        started_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        started_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    d_busywait = d_req & ~d_done & ~reset;
    i_busywait = i_req & ~i_done & ~reset;
  end

  // State, grant history and returned read blocks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      started_q    <= 1'b0;
      last_grant_q <= GRANT_I;
      d_readdata   <= DATA_W'(0);
      i_readdata   <= DATA_W'(0);
    end else begin
      state_q      <= state_d;
      started_q    <= started_d;
      last_grant_q <= last_grant_d;
      if (d_load) d_readdata <= mem_readdata;
      if (i_load) i_readdata <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, cache-like
// requester tasks and a transaction-level reference (expected memory image,
// grant order, fairness bound).
module tb_mem_arbiter;

  localparam int TIMEOUT = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_read, d_write;
  logic [5:0]  d_address;
  logic [31:0] d_writedata, d_readdata;
  logic        d_busywait;
  logic        i_read;
  logic [5:0]  i_address;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_readdata(d_readdata), .d_busywait(d_busywait),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
    .i_busywait(i_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  // Behavioural memory: busy for (lat+1) cycles after seeing a request,
  // aborts if the request vanishes, waits for an idle cycle before restarting.
  logic [31:0] mem_array [64];
  logic [31:0] mem_rdata;
  logic        mem_busy, mem_hold;
  int          mem_cnt;
  int          mem_lat = 2;
  bit          lat_rand = 1'b0;

  assign mem_busywait = mem_busy;
  assign mem_readdata = mem_rdata;

  always @(posedge clk) begin
    if (reset) begin
      mem_busy <= 1'b0;
      mem_hold <= 1'b0;
      mem_cnt  <= 0;
    end else if (mem_busy) begin
      if (!(mem_read || mem_write)) mem_busy <= 1'b0;
      else if (mem_cnt == 0) begin
        mem_busy <= 1'b0;
        mem_hold <= 1'b1;
      end else mem_cnt <= mem_cnt - 1;
    end else if (mem_hold) begin
      if (!(mem_read || mem_write)) mem_hold <= 1'b0;
    end else if (mem_read || mem_write) begin
      mem_busy  <= 1'b1;
      mem_cnt   <= lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
      if (mem_write) mem_array[mem_address] <= mem_writedata;
      mem_rdata <= mem_array[mem_address];
    end
  end

  // Reference state
  logic [31:0] dref [64];
  logic [31:0] d_hold, i_hold;
  int          d_done_cnt = 0, i_done_cnt = 0;
  bit          order [$];
  bit          mon_en = 1'b0;

  function automatic logic [31:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, b, b, b};
  endfunction

  // Port steering monitor: any active memory command must mirror a requester
  always @(negedge clk) begin
    if (mon_en && (mem_read || mem_write)) begin
      tests_run++;
      if (!(((d_read || d_write) && mem_read === d_read && mem_write === d_write &&
             mem_address === d_address && mem_writedata === d_writedata) ||
            (i_read && mem_read === 1'b1 && mem_write === 1'b0 &&
             mem_address === i_address && mem_writedata === 32'h0))) begin
        tests_failed++;
        $display("FAIL mem_steer: rd=%b wr=%b addr=%0d wdata=%h not matching any requester",
                 mem_read, mem_write, mem_address, mem_writedata);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic d_access(input bit rd, input logic [5:0] addr, input logic [31:0] wdata);
    int  start_other;
    bit  got;
    d_read      = rd;
    d_write     = !rd;
    d_address   = addr;
    d_writedata = rd ? 32'h0 : wdata;
    start_other = i_done_cnt;
    got = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      if (!d_busywait) begin
        got = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL d_timeout: addr=%0d busywait stuck at %b, required 0", addr, d_busywait);
      d_read = 1'b0;
      d_write = 1'b0;
      return;
    end
    d_done_cnt++;
    order.push_back(1'b0);
    tests_run++;
    if (i_done_cnt - start_other > 1) begin
      tests_failed++;
      $display("FAIL d_fairness: %0d I accesses while D waited, required <= 1",
               i_done_cnt - start_other);
    end
    @(posedge clk);
    #1;
    d_read  = 1'b0;
    d_write = 1'b0;
    if (rd) d_hold = dref[addr];
    else    dref[addr] = wdata;
    tests_run++;
    if (d_readdata !== d_hold) begin
      tests_failed++;
      $display("FAIL d_readdata: addr=%0d got %h, required %h", addr, d_readdata, d_hold);
    end
    tests_run++;
    if (i_readdata !== i_hold) begin
      tests_failed++;
      $display("FAIL i_hold_during_d: got %h, required %h", i_readdata, i_hold);
    end
  endtask

  task automatic i_access(input logic [5:0] addr);
    int start_other;
    bit got;
    i_read      = 1'b1;
    i_address   = addr;
    start_other = d_done_cnt;
    got = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      if (!i_busywait) begin
        got = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL i_timeout: addr=%0d busywait stuck at %b, required 0", addr, i_busywait);
      i_read = 1'b0;
      return;
    end
    i_done_cnt++;
    order.push_back(1'b1);
    tests_run++;
    if (d_done_cnt - start_other > 1) begin
      tests_failed++;
      $display("FAIL i_fairness: %0d D accesses while I waited, required <= 1",
               d_done_cnt - start_other);
    end
    @(posedge clk);
    #1;
    i_read = 1'b0;
    i_hold = pat(int'(addr));
    tests_run++;
    if (i_readdata !== i_hold) begin
      tests_failed++;
      $display("FAIL i_readdata: addr=%0d got %h, required %h", addr, i_readdata, i_hold);
    end
    tests_run++;
    if (d_readdata !== d_hold) begin
      tests_failed++;
      $display("FAIL d_hold_during_i: got %h, required %h", d_readdata, d_hold);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    d_hold = 32'h0;
    i_hold = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d_read = 1'b1; d_write = 1'b0; d_address = 6'd1; d_writedata = 32'h0;
    i_read = 1'b1; i_address = 6'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (d_busywait !== 1'b0 || i_busywait !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busywait: d=%b i=%b, required 0 0", d_busywait, i_busywait);
    end
    tests_run++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%0d, required 0 0 0",
               mem_read, mem_write, mem_address);
    end
    tests_run++;
    if (d_readdata !== 32'h0 || i_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_readdata: d=%h i=%h, required 0 0", d_readdata, i_readdata);
    end
    @(posedge clk);
    #1;
    d_read = 1'b0;
    i_read = 1'b0;
    reset  = 1'b0;
    d_hold = 32'h0;
    i_hold = 32'h0;
  endtask

  task automatic test_single_read();
    bit got;
    mem_lat = 2;
    @(posedge clk);
    #1;
    d_read = 1'b1; d_write = 1'b0; d_address = 6'd5;
    @(negedge clk);
    tests_run++;
    if (mem_read !== 1'b0 || d_busywait !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_idle_cycle: mem_read=%b d_busywait=%b, required 0 1", mem_read, d_busywait);
    end
    @(negedge clk);
    tests_run++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 6'd5) begin
      tests_failed++;
      $display("FAIL read_grant: rd=%b wr=%b addr=%0d, required 1 0 5",
               mem_read, mem_write, mem_address);
    end
    got = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      tests_run++;
      if (mem_busywait) begin
        if (d_busywait !== 1'b1) begin
          tests_failed++;
          $display("FAIL read_stall: d_busywait=%b while memory busy, required 1", d_busywait);
        end
      end else begin
        got = 1'b1;
        if (d_busywait !== 1'b0) begin
          tests_failed++;
          $display("FAIL read_complete: d_busywait=%b when memory done, required 0", d_busywait);
        end
        break;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL read_timeout: mem_busywait=%b, required 0", mem_busywait);
    end
    @(posedge clk);
    #1;
    d_read = 1'b0;
    d_hold = dref[5];
    tests_run++;
    if (d_readdata !== 32'h05050505) begin
      tests_failed++;
      $display("FAIL read_data: got %h, required 05050505", d_readdata);
    end
    @(negedge clk);
    tests_run++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_release: rd=%b wr=%b, required 0 0", mem_read, mem_write);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_write();
    bit seen;
    seen = 1'b0;
    fork
      d_access(1'b0, 6'h21, 32'hDEADBEEF);
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (mem_write) begin
            seen = 1'b1;
            tests_run++;
            if (mem_address !== 6'h21 || mem_writedata !== 32'hDEADBEEF || mem_read !== 1'b0) begin
              tests_failed++;
              $display("FAIL write_port: addr=%h data=%h rd=%b, required 21 deadbeef 0",
                       mem_address, mem_writedata, mem_read);
            end
            break;
          end
        end
      end
    join
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL write_seen: mem_write never %b, required 1", 1'b1);
    end
    d_access(1'b1, 6'h21, 32'h0);
  endtask

  task automatic test_tie();
    logic       lg_rd [64];
    logic [5:0] lg_addr [64];
    logic       lg_ibw [64];
    int r;
    apply_reset();
    order.delete();
    fork
      d_access(1'b1, 6'd40, 32'h0);
      i_access(6'd20);
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          lg_rd[k]   = mem_read;
          lg_addr[k] = mem_address;
          lg_ibw[k]  = i_busywait;
        end
      end
    join
    tests_run++;
    if (lg_rd[1] !== 1'b1 || lg_addr[1] !== 6'd40) begin
      tests_failed++;
      $display("FAIL tie_first: rd=%b addr=%0d, required 1 40", lg_rd[1], lg_addr[1]);
    end
    r = 2;
    while (r < 27 && lg_rd[r] === 1'b1) r++;
    tests_run++;
    if (lg_rd[r+1] !== 1'b0 || lg_rd[r+2] !== 1'b1 || lg_addr[r+2] !== 6'd20) begin
      tests_failed++;
      $display("FAIL tie_i_grant: after release rd=%b,%b addr=%0d, required 0,1 20",
               lg_rd[r+1], lg_rd[r+2], lg_addr[r+2]);
    end
    for (int k = 0; k <= r + 2; k++) begin
      tests_run++;
      if (lg_ibw[k] !== 1'b1) begin
        tests_failed++;
        $display("FAIL tie_i_wait: cycle %0d i_busywait=%b, required 1", k, lg_ibw[k]);
      end
    end
  endtask

  task automatic test_fairness();
    bit exp [4];
    exp[0] = 1'b0; exp[1] = 1'b1; exp[2] = 1'b0; exp[3] = 1'b1;
    order.delete();
    fork
      begin
        d_access(1'b1, 6'd33, 32'h0);
        d_access(1'b1, 6'd2, 32'h0);
      end
      begin
        i_access(6'd3);
        i_access(6'd4);
      end
    join
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (order.size() <= k || order[k] !== exp[k]) begin
        tests_failed++;
        $display("FAIL fair_order: slot %0d got %s, required %s", k,
                 (order.size() <= k) ? "none" : (order[k] ? "I" : "D"), exp[k] ? "I" : "D");
      end
    end
  endtask

  task automatic test_withdraw();
    bit got;
    d_access(1'b1, 6'd3, 32'h0);
    mem_lat = 6;
    i_read = 1'b1;
    i_address = 6'd7;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_read) begin
        got = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL wd_grant: mem_read=%b, required 1", mem_read);
    end
    repeat (3) @(posedge clk);
    #1;
    i_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (i_busywait !== 1'b0 || mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_drop: i_busywait=%b mem_read=%b, required 0 0", i_busywait, mem_read);
    end
    @(negedge clk);
    tests_run++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_release: rd=%b wr=%b, required 0 0", mem_read, mem_write);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (i_readdata !== i_hold) begin
      tests_failed++;
      $display("FAIL wd_readdata: got %h, required %h", i_readdata, i_hold);
    end
    mem_lat = 2;
    order.delete();
    fork
      d_access(1'b1, 6'd8, 32'h0);
      i_access(6'd9);
    join
    tests_run++;
    if (order.size() < 1 || order[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_last_grant: first after withdrawal got %s, required D",
               (order.size() < 1) ? "none" : (order[0] ? "I" : "D"));
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    mem_lat = 5;
    @(posedge clk);
    #1;
    d_read = 1'b1; d_write = 1'b0; d_address = 6'd10;
    i_read = 1'b1; i_address = 6'd11;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_read) begin
        got = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!got || mem_address !== 6'd10) begin
      tests_failed++;
      $display("FAIL rm_grant: mem_read=%b addr=%0d, required 1 10", mem_read, mem_address);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (d_busywait !== 1'b0 || i_busywait !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_busywait: d=%b i=%b, required 0 0", d_busywait, i_busywait);
    end
    @(negedge clk);
    tests_run++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_mem: rd=%b wr=%b, required 0 0", mem_read, mem_write);
    end
    tests_run++;
    if (d_readdata !== 32'h0 || i_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rm_readdata: d=%h i=%h, required 0 0", d_readdata, i_readdata);
    end
    @(posedge clk);
    #1;
    d_read = 1'b0;
    i_read = 1'b0;
    reset  = 1'b0;
    d_hold = 32'h0;
    i_hold = 32'h0;
    mem_lat = 2;
    d_access(1'b1, 6'd12, 32'h0);
  endtask

  task automatic rand_d_proc(input int n);
    bit          rd;
    logic [5:0]  a;
    logic [31:0] w;
    int          g;
    for (int k = 0; k < n; k++) begin
      rd = bit'($urandom_range(0, 1));
      a  = rd ? 6'($urandom_range(0, 63)) : 6'($urandom_range(32, 63));
      w  = $urandom;
      g  = int'($urandom_range(0, 3));
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      d_access(rd, a, w);
    end
  endtask

  task automatic rand_i_proc(input int n);
    logic [5:0] a;
    int         g;
    for (int k = 0; k < n; k++) begin
      a = 6'($urandom_range(0, 31));
      g = int'($urandom_range(0, 3));
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      i_access(a);
    end
  endtask

  task automatic test_random();
    lat_rand = 1'b1;
    mon_en   = 1'b1;
    fork
      rand_d_proc(30);
      rand_i_proc(30);
    join
    mon_en   = 1'b0;
    lat_rand = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin
      mem_array[a] = pat(a);
      dref[a]      = pat(a);
    end
    d_hold = 32'h0;
    i_hold = 32'h0;
    test_reset();
    test_single_read();
    test_single_write();
    test_tie();
    test_fairness();
    test_withdraw();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
